// File: rtl/phys_free_list_if.sv
`default_nettype none
// ============================================================================
//  Module      : phys_free_list_if
//  Description : Rename/commit-side bundle for the physical tag free list.
//                The master drives the allocate request and the two release
//                slots. The slave (the free list) returns the head tag,
//                the availability flag, the occupancy and the sticky error.
//  Revision    : 1.0 - initial release
// ============================================================================
interface phys_free_list_if #(
    parameter int TAG_W = 6
);
    logic             alloc_req;
    logic             alloc_valid;
    logic [TAG_W-1:0] alloc_tag;
    logic             free_valid_1;
    logic [TAG_W-1:0] free_tag_1;
    logic             free_valid_2;
    logic [TAG_W-1:0] free_tag_2;
    logic [TAG_W:0]   free_count;
    logic             overflow_err;

    modport master (
        output alloc_req,
        output free_valid_1,
        output free_tag_1,
        output free_valid_2,
        output free_tag_2,
        input  alloc_valid,
        input  alloc_tag,
        input  free_count,
        input  overflow_err
    );

    modport slave (
        input  alloc_req,
        input  free_valid_1,
        input  free_tag_1,
        input  free_valid_2,
        input  free_tag_2,
        output alloc_valid,
        output alloc_tag,
        output free_count,
        output overflow_err
    );
endinterface
`default_nettype wire

// File: rtl/phys_free_list.sv
`default_nettype none
// ============================================================================
//  Module      : phys_free_list
//  Description : Circular free list of physical register tags. It hands
//                one tag per cycle to rename and accepts up to two released
//                tags per cycle from commit. Tag 0 (the x0 mapping) is never
//                stored. Frees that would overfill the list are dropped,
//                and a sticky error is raised.
//  Revision    : 1.0 - initial release
// ============================================================================
module phys_free_list #(
    parameter int NUM_PHYS = 64,
    parameter int NUM_ARCH = 32,
    parameter int TAG_W    = 6
) (
    input  wire logic         clk,
    input  wire logic         reset,
    phys_free_list_if.slave   fl
);
    localparam int              INIT_FREE = NUM_PHYS - NUM_ARCH;
    localparam logic [TAG_W:0]  CAPACITY  = (TAG_W+1)'(NUM_PHYS - 1);

    logic [TAG_W-1:0] mem_q [NUM_PHYS];
    logic [TAG_W-1:0] head_q, head_d;
    logic [TAG_W-1:0] tail_q, tail_d;
    logic [TAG_W:0]   count_q, count_d;
    logic             ovf_q, ovf_d;

    logic             w_pop;
    logic             w_eff_1, w_eff_2;
    logic             w_acc_1, w_acc_2;
    logic [TAG_W:0]   w_cnt_after_pop;
    logic [TAG_W-1:0] w_wr_idx_2;

    // Decide the pop, filter and admit the frees, and form all next-state values
    always_comb begin
        w_pop           = fl.alloc_req && (count_q != '0);
        w_eff_1         = fl.free_valid_1 && (fl.free_tag_1 != '0);
        w_eff_2         = fl.free_valid_2 && (fl.free_tag_2 != '0);
        // Capacity is judged after the same-cycle pop has made room
        w_cnt_after_pop = count_q - (TAG_W+1)'(w_pop);
        // Slot 1 has priority for the remaining room, so slot 2 drops first
        w_acc_1         = w_eff_1 && (w_cnt_after_pop < CAPACITY);
        w_acc_2         = w_eff_2 && ((w_cnt_after_pop + (TAG_W+1)'(w_acc_1)) < CAPACITY);
        w_wr_idx_2      = tail_q + TAG_W'(w_acc_1);
        head_d          = head_q + TAG_W'(w_pop);
        tail_d          = tail_q + TAG_W'(w_acc_1) + TAG_W'(w_acc_2);
        count_d         = w_cnt_after_pop + (TAG_W+1)'(w_acc_1) + (TAG_W+1)'(w_acc_2);
        ovf_d           = ovf_q || (w_eff_1 && !w_acc_1) || (w_eff_2 && !w_acc_2);
    end

    // Pointers, occupancy and sticky error; reset restores the post-boot map
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= TAG_W'(INIT_FREE);
            count_q <= (TAG_W+1)'(INIT_FREE);
            ovf_q   <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    // Tag storage: the unmapped tags NUM_ARCH.. are preloaded, and accepted frees are written at the tail
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NUM_PHYS; k++) begin
                mem_q[k] <= (k < INIT_FREE) ? TAG_W'(NUM_ARCH + k) : '0;
            end
        end else begin
            if (w_acc_1) begin
                mem_q[tail_q] <= fl.free_tag_1;
            end
            if (w_acc_2) begin
                mem_q[w_wr_idx_2] <= fl.free_tag_2;
            end
        end
    end

    // Outputs depend only on registered state
    always_comb begin
        fl.alloc_valid  = (count_q != '0);
        fl.alloc_tag    = mem_q[head_q];
        fl.free_count   = count_q;
        fl.overflow_err = ovf_q;
    end
endmodule
`default_nettype wire
